mult_share_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one combinational 8x8 multiplier datapath among NREQ requesters. Accepts operand pairs over per-requester valid/ready handshakes and drives registered operands to the multiplier. Captures the product one cycle later and returns it with the requester ID over a single response channel with backpressure. Sits between client blocks and the single multiplier instance.

---
 rtl/mult_share_arbiter.sv | 133 +++++++++++++
 tb/tb_mult_share_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_share_arbiter.sv
// Round-robin sharing of one combinational multiplier among NREQ requesters.
// Optional per-requester accumulators when MULT_ARB_ACCUM_EN is defined.
module mult_share_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [W-1:0]      mul_a,
  output logic [W-1:0]      mul_b,
  input  logic [2*W-1:0]    mul_prod,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [2*W-1:0]    rsp_prod,
`ifdef MULT_ARB_ACCUM_EN
  input  logic [NREQ-1:0]   req_clr,
  output logic [2*W+3:0]    rsp_acc,
`endif
  output logic              busy
);

  typedef enum logic [1:0] {
    st_idle,
    st_exec,
    st_resp
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [IDW-1:0]  rr_ptr;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_idx;
  logic            found;
  logic            accept;
  int              j;

  // Search starts just past the last winner, wrapping around.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    j       = 0;
    for (int k = 1; k <= NREQ; k++) begin
      j = (int'(rr_ptr) + k) % NREQ;
      if (!found && req_valid[j]) begin
        found   = 1'b1;
        gnt_idx = IDW'(j);
        gnt[j]  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    accept    = 1'b0;
    unique case (state_q)
      st_idle: begin
        req_ready = gnt;
        if (found) begin
          accept  = 1'b1;
          state_d = st_exec;
        end
      end
      st_exec: state_d = st_resp;
      st_resp: if (rsp_ready) state_d = st_idle;
      default: state_d = st_idle;
    endcase
  end

  assign busy = (state_q != st_idle);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= st_idle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mul_a     <= '0;
      mul_b     <= '0;
      rsp_id    <= '0;
      rsp_prod  <= '0;
      rsp_valid <= 1'b0;
      rr_ptr    <= IDW'(NREQ - 1);
    end else begin
      if (accept) begin
        mul_a  <= req_a[int'(gnt_idx)*W +: W];
        mul_b  <= req_b[int'(gnt_idx)*W +: W];
        rsp_id <= gnt_idx;
        rr_ptr <= gnt_idx;
      end
      if (state_q == st_exec) begin
        rsp_prod  <= mul_prod;
        rsp_valid <= 1'b1;
      end else if (state_q == st_resp && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

`ifdef MULT_ARB_ACCUM_EN
  logic [2*W+3:0] acc [NREQ];
  logic [2*W+3:0] acc_nxt;
  logic           clr_q;

  assign acc_nxt = (clr_q ? '0 : acc[rsp_id]) + (2*W+4)'(mul_prod);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clr_q   <= 1'b0;
      rsp_acc <= '0;
      for (int i = 0; i < NREQ; i++) acc[i] <= '0;
    end else begin
      if (accept) clr_q <= req_clr[gnt_idx];
      if (state_q == st_exec) begin
        acc[rsp_id] <= acc_nxt;
        rsp_acc     <= acc_nxt;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Self-checking bench for mult_share_arbiter.
// Accumulator checks are compiled in when MULT_ARB_ACCUM_EN is defined.
module tb_mult_share_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int IDW  = 2;
  localparam int AW   = 2*W+4;

  logic              clk = 0;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [W-1:0]      mul_a;
  logic [W-1:0]      mul_b;
  logic [2*W-1:0]    mul_prod;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [2*W-1:0]    rsp_prod;
  logic              busy;
  logic [NREQ-1:0]   req_clr;
`ifdef MULT_ARB_ACCUM_EN
  logic [AW-1:0]     rsp_acc;
`endif

  always #5 clk = ~clk;

  assign mul_prod = mul_a * mul_b;

  mult_share_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a(req_a),
    .req_b(req_b),
    .mul_a(mul_a),
    .mul_b(mul_b),
    .mul_prod(mul_prod),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_id(rsp_id),
    .rsp_prod(rsp_prod),
`ifdef MULT_ARB_ACCUM_EN
    .req_clr(req_clr),
    .rsp_acc(rsp_acc),
`endif
    .busy(busy)
  );

  int            n_chk  = 0;
  int            n_fail = 0;
  int            rr_m;
  logic [W-1:0]  oa [NREQ];
  logic [W-1:0]  ob [NREQ];
  logic [AW-1:0] acc_m [NREQ];
  logic [NREQ-1:0] clr_m;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] v);
    for (int k = 1; k <= NREQ; k++) begin
      if (v[(rr_m + k) % NREQ]) return (rr_m + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic load();
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*W +: W] = oa[i];
      req_b[i*W +: W] = ob[i];
    end
    req_clr = clr_m;
  endtask

  task automatic model_reset();
    rr_m = NREQ - 1;
    for (int i = 0; i < NREQ; i++) acc_m[i] = '0;
  endtask

  task automatic op(input logic [NREQ-1:0] v, input int stall);
    int g;
    logic [2*W-1:0] p;
    req_valid = v;
    rsp_ready = 1'b0;
    load();
    #1;
    g = pick(v);
    if (g < 0) begin
      chk("idle_rdy", 32'(req_ready), 0);
      @(posedge clk); #1;
      chk("idle_busy", 32'(busy), 0);
      return;
    end
    p = 16'(oa[g]) * 16'(ob[g]);
    chk("grant", 32'(req_ready), 32'(1) << g);
    chk("idle_busy", 32'(busy), 0);
    @(posedge clk); #1;
    chk("exec_busy", 32'(busy), 1);
    chk("exec_rdy", 32'(req_ready), 0);
    chk("mul_a", 32'(mul_a), 32'(oa[g]));
    chk("mul_b", 32'(mul_b), 32'(ob[g]));
    chk("exec_vld", 32'(rsp_valid), 0);
    @(posedge clk); #1;
    acc_m[g] = (clr_m[g] ? '0 : acc_m[g]) + AW'(p);
    chk("rsp_vld", 32'(rsp_valid), 1);
    chk("rsp_id", 32'(rsp_id), 32'(g));
    chk("rsp_prod", 32'(rsp_prod), 32'(p));
`ifdef MULT_ARB_ACCUM_EN
    chk("rsp_acc", 32'(rsp_acc), 32'(acc_m[g]));
`endif
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      chk("hold_vld", 32'(rsp_valid), 1);
      chk("hold_id", 32'(rsp_id), 32'(g));
      chk("hold_prod", 32'(rsp_prod), 32'(p));
      chk("hold_rdy", 32'(req_ready), 0);
      chk("hold_busy", 32'(busy), 1);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("retire_vld", 32'(rsp_valid), 0);
    chk("retire_busy", 32'(busy), 0);
    rsp_ready = 1'b0;
    rr_m = g;
  endtask

  initial begin
    reset     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    clr_m     = '0;
    for (int i = 0; i < NREQ; i++) begin
      oa[i] = '0;
      ob[i] = '0;
    end
    load();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vld", 32'(rsp_valid), 0);
    chk("rst_id", 32'(rsp_id), 0);
    chk("rst_prod", 32'(rsp_prod), 0);
    chk("rst_mula", 32'(mul_a), 0);
    chk("rst_mulb", 32'(mul_b), 0);
    chk("rst_busy", 32'(busy), 0);
    reset = 1'b1;

    // stray rsp_ready while idle
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("stray_rdy", 32'(rsp_valid), 0);
    chk("stray_busy", 32'(busy), 0);

    oa[0] = 8'd12;
    ob[0] = 8'd13;
    op(4'b0001, 0);
    chk("single_ptr", 32'(rr_m), 0);

    model_reset();
    reset = 1'b0;
    #1;
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        oa[i] = W'($urandom);
        ob[i] = W'($urandom);
      end
      op(4'b1111, 0);
      chk("rr_order", 32'(rr_m), 32'(k % NREQ));
    end

    oa[2] = W'($urandom);
    ob[2] = W'($urandom);
    op(4'b0100, 5);

    oa[1] = 8'd255;
    ob[1] = 8'd255;
    op(4'b0010, 0);
    oa[3] = 8'd0;
    ob[3] = 8'd200;
    op(4'b1000, 1);

    for (int k = 0; k < 40; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        oa[i] = W'($urandom);
        ob[i] = W'($urandom);
      end
      clr_m = NREQ'($urandom);
      op(NREQ'($urandom), int'($urandom_range(0, 2)));
    end
    clr_m = '0;

    // reset while the multiply is executing
    oa[3] = 8'd7;
    ob[3] = 8'd9;
    load();
    req_valid = 4'b1000;
    @(posedge clk); #1;
    chk("mid_busy", 32'(busy), 1);
    reset = 1'b0;
    #1;
    chk("mid_vld", 32'(rsp_valid), 0);
    chk("mid_busy0", 32'(busy), 0);
    chk("mid_mula", 32'(mul_a), 0);
    model_reset();
    req_valid = 4'b0110;
    @(posedge clk); #1;
    chk("mid_vld2", 32'(rsp_valid), 0);
    reset = 1'b1;
    oa[1] = 8'd5;
    ob[1] = 8'd6;
    op(4'b0110, 0);
    chk("mid_lowest", 32'(rr_m), 1);

`ifdef MULT_ARB_ACCUM_EN
    clr_m    = 4'b0100;
    oa[2]    = 8'd10;
    ob[2]    = 8'd10;
    op(4'b0100, 0);
    chk("acc_100", 32'(acc_m[2]), 100);
    clr_m    = '0;
    oa[2]    = 8'd3;
    ob[2]    = 8'd4;
    op(4'b0100, 0);
    chk("acc_112", 32'(acc_m[2]), 112);
    oa[0]    = 8'd255;
    ob[0]    = 8'd255;
    clr_m    = 4'b0001;
    op(4'b0001, 0);
    clr_m    = '0;
    for (int k = 0; k < 16; k++) op(4'b0001, 0);
    chk("acc_wrap", 32'(acc_m[0]), 32'd56849);
`endif

    req_valid = '0;
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
